// File: rtl/anabellek_denetleyici_if.sv
// Cache-side and memory-side signal bundle of the main-memory controller.
// The controller connects through the slave modport; the cache/memory side uses master.
interface anabellek_denetleyici_if;
  logic         istek_i;
  logic         yaz_i;
  logic         oku_i;
  logic [31:0]  adres_i;
  logic [127:0] kirli_obek_i;
  logic         musait_o;
  logic         hazir_o;
  logic [127:0] obek_o;
  logic         bellek_istek_o;
  logic         bellek_yaz_o;
  logic [31:0]  bellek_adres_o;
  logic [31:0]  bellek_veri_o;
  logic         bellek_kabul_i;
  logic [31:0]  bellek_veri_i;

  modport slave (
    input  istek_i, yaz_i, oku_i, adres_i, kirli_obek_i, bellek_kabul_i, bellek_veri_i,
    output musait_o, hazir_o, obek_o, bellek_istek_o, bellek_yaz_o, bellek_adres_o, bellek_veri_o
  );

  modport master (
    output istek_i, yaz_i, oku_i, adres_i, kirli_obek_i, bellek_kabul_i, bellek_veri_i,
    input  musait_o, hazir_o, obek_o, bellek_istek_o, bellek_yaz_o, bellek_adres_o, bellek_veri_o
  );
endinterface

// File: rtl/anabellek_denetleyici.sv
// Main-memory controller: turns 128-bit block refill/write-back requests into
// 4-beat bursts of 32-bit words on the memory request/accept bus.
module anabellek_denetleyici (
  input  logic                   clk_i,
  input  logic                   rst_i,
  anabellek_denetleyici_if.slave bus
);
  localparam int unsigned OBEK_BIT = 128;
  localparam int unsigned VERI_BIT = 32;

  typedef enum logic [1:0] {BOSTA, VURUS, TAMAM} durum_t;

  durum_t              durum_q, durum_d;
  logic [1:0]          k_q, k_d;
  logic [31:0]         taban_q, taban_d;
  logic                yon_q, yon_d;
  logic [OBEK_BIT-1:0] blok_q, blok_d;
  logic [OBEK_BIT-1:0] obek_q, obek_d;

  logic                istek_d, yaz_d, hazir_d, vurus_d;
  logic [31:0]         adres_d, veri_d;
  logic                musait, kabul_et;

  assign musait       = (durum_q == BOSTA) || (durum_q == TAMAM);
  assign kabul_et     = bus.istek_i && musait && (bus.yaz_i ^ bus.oku_i);
  assign bus.musait_o = musait;
  assign bus.obek_o   = obek_q;

  always_comb begin
    durum_d = durum_q;
    k_d     = k_q;
    taban_d = taban_q;
    yon_d   = yon_q;
    blok_d  = blok_q;
    obek_d  = obek_q;
    unique case (durum_q)
      BOSTA, TAMAM: begin
        durum_d = BOSTA;
        if (kabul_et) begin
          durum_d = VURUS;
          k_d     = '0;
          taban_d = {bus.adres_i[31:4], 4'h0};
          yon_d   = bus.yaz_i;
          blok_d  = bus.kirli_obek_i;
        end
      end
      VURUS: begin
        if (bus.bellek_kabul_i) begin
          if (!yon_q) obek_d[{k_q, 5'b0} +: VERI_BIT] = bus.bellek_veri_i;
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) durum_d = TAMAM;
        end
      end
      default: durum_d = BOSTA;
    endcase

    // Bus outputs are registered from the next-state view so each beat
    // appears in the cycle right after acceptance or the previous kabul.
    vurus_d = (durum_d == VURUS);
    istek_d = vurus_d;
    yaz_d   = vurus_d && yon_d;
    adres_d = vurus_d ? (taban_d + {28'h0, k_d, 2'b00}) : '0;
    veri_d  = (vurus_d && yon_d) ? blok_d[{k_d, 5'b0} +: VERI_BIT] : '0;
    hazir_d = (durum_d == TAMAM);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q            <= BOSTA;
      k_q                <= '0;
      taban_q            <= '0;
      yon_q              <= 1'b0;
      blok_q             <= '0;
      obek_q             <= '0;
      bus.hazir_o        <= 1'b0;
      bus.bellek_istek_o <= 1'b0;
      bus.bellek_yaz_o   <= 1'b0;
      bus.bellek_adres_o <= '0;
      bus.bellek_veri_o  <= '0;
    end else begin
      durum_q            <= durum_d;
      k_q                <= k_d;
      taban_q            <= taban_d;
      yon_q              <= yon_d;
      blok_q             <= blok_d;
      obek_q             <= obek_d;
      bus.hazir_o        <= hazir_d;
      bus.bellek_istek_o <= istek_d;
      bus.bellek_yaz_o   <= yaz_d;
      bus.bellek_adres_o <= adres_d;
      bus.bellek_veri_o  <= veri_d;
    end
  end
endmodule

// File: tb/tb_anabellek_denetleyici.sv
// Self-checking bench for anabellek_denetleyici: directed plan cases plus
// randomized back-to-back bursts against a block-level memory model.
module tb_anabellek_denetleyici;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  anabellek_denetleyici_if bus();
  anabellek_denetleyici dut (.clk_i(clk), .rst_i(rst_n), .bus(bus.slave));

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]  salt;
  logic [127:0] exp_obek;
  int           stall [4];
  bit           noise;

  logic [31:0]  obs_adr [4];
  logic [31:0]  obs_dat [4];
  logic         obs_yaz [4];
  int           obs_beats, obs_hz_cyc, obs_first_cyc, obs_unstable;
  logic [127:0] obs_obek;

  // Memory content: word at address A is A ^ salt.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ salt;
  endfunction

  function automatic logic [127:0] model_read(input logic [31:0] adr);
    logic [31:0] b;
    b = {adr[31:4], 4'h0};
    return {mem_word(b + 32'd12), mem_word(b + 32'd8), mem_word(b + 32'd4), mem_word(b)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.istek_i = 1'b0; bus.yaz_i = 1'b0; bus.oku_i = 1'b0;
    bus.adres_i = $urandom;
    bus.kirli_obek_i = {$urandom, $urandom, $urandom, $urandom};
    bus.bellek_kabul_i = 1'b0;
    bus.bellek_veri_i = $urandom;
  endtask

  // Presents a request in the current cycle and plays memory until hazir_o;
  // returns in the hazir_o cycle so a follow-up request can be chained there.
  task automatic do_burst(input logic wr, input logic [31:0] adr, input logic [127:0] data);
    int cyc, left;
    bit held;
    logic [31:0] h_adr, h_dat;
    logic h_yaz;
    bus.istek_i = 1'b1; bus.yaz_i = wr; bus.oku_i = ~wr;
    bus.adres_i = adr; bus.kirli_obek_i = data;
    bus.bellek_kabul_i = 1'b0;
    obs_beats = 0; obs_hz_cyc = -1; obs_first_cyc = -1; obs_unstable = 0;
    cyc = 0; left = stall[0]; held = 0;
    h_adr = '0; h_dat = '0; h_yaz = 1'b0;
    while (obs_hz_cyc < 0 && cyc < 200) begin
      step();
      cyc++;
      idle_inputs();
      if (bus.hazir_o) begin
        obs_hz_cyc = cyc;
        obs_obek = bus.obek_o;
      end else if (bus.bellek_istek_o) begin
        if (obs_first_cyc < 0) obs_first_cyc = cyc;
        if (noise) begin
          bus.istek_i = 1'b1; bus.yaz_i = $urandom_range(0, 1); bus.oku_i = ~bus.yaz_i;
        end
        if (!held) begin
          h_adr = bus.bellek_adres_o; h_dat = bus.bellek_veri_o; h_yaz = bus.bellek_yaz_o;
          held = 1;
        end else if (bus.bellek_adres_o !== h_adr || bus.bellek_veri_o !== h_dat ||
                     bus.bellek_yaz_o !== h_yaz) begin
          obs_unstable++;
        end
        if (left > 0) begin
          left--;
        end else begin
          if (obs_beats < 4) begin
            obs_adr[obs_beats] = bus.bellek_adres_o;
            obs_dat[obs_beats] = bus.bellek_veri_o;
            obs_yaz[obs_beats] = bus.bellek_yaz_o;
          end
          obs_beats++;
          bus.bellek_kabul_i = 1'b1;
          if (!bus.bellek_yaz_o) bus.bellek_veri_i = mem_word(bus.bellek_adres_o);
          held = 0;
          if (obs_beats < 4) left = stall[obs_beats];
        end
      end
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (bus.musait_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_musait got %0b exp 1", bus.musait_o);
    end
    n_tests++;
    if ({bus.hazir_o, bus.bellek_istek_o, bus.bellek_yaz_o, bus.bellek_adres_o, bus.bellek_veri_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs got hz=%0b ist=%0b yaz=%0b adr=%h veri=%h exp all 0",
               bus.hazir_o, bus.bellek_istek_o, bus.bellek_yaz_o, bus.bellek_adres_o, bus.bellek_veri_o);
    end
    n_tests++;
    if (bus.obek_o !== 128'h0) begin
      n_fail++; $display("FAIL reset_obek got %h exp 0", bus.obek_o);
    end
  endtask

  task automatic test_read_basic();
    salt = '0; noise = 0;
    foreach (stall[i]) stall[i] = 0;
    do_burst(1'b0, 32'h0000_1234, {$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({obs_adr[i], obs_dat[i], obs_yaz[i]} !== {32'h0000_1230 + 32'(4 * i), 32'h0, 1'b0}) begin
        n_fail++;
        $display("FAIL read_beat%0d got adr=%h veri=%h yaz=%0b exp adr=%h veri=0 yaz=0",
                 i, obs_adr[i], obs_dat[i], obs_yaz[i], 32'h0000_1230 + 32'(4 * i));
      end
    end
    n_tests++;
    if (obs_first_cyc != 1 || obs_hz_cyc != 5) begin
      n_fail++; $display("FAIL read_timing got first=%0d hazir=%0d exp 1 and 5", obs_first_cyc, obs_hz_cyc);
    end
    exp_obek = 128'h0000123C_00001238_00001234_00001230;
    n_tests++;
    if (obs_obek !== exp_obek) begin
      n_fail++; $display("FAIL read_obek got %h exp %h", obs_obek, exp_obek);
    end
    step();
    n_tests++;
    if (bus.hazir_o !== 1'b0 || bus.bellek_istek_o !== 1'b0 || bus.obek_o !== exp_obek) begin
      n_fail++;
      $display("FAIL read_after got hz=%0b ist=%0b obek=%h exp 0 0 %h",
               bus.hazir_o, bus.bellek_istek_o, bus.obek_o, exp_obek);
    end
  endtask

  task automatic test_write_back();
    logic [127:0] d;
    d = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    noise = 0;
    foreach (stall[i]) stall[i] = 0;
    do_burst(1'b1, 32'h8000_0040, d);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({obs_adr[i], obs_dat[i], obs_yaz[i]} !== {32'h8000_0040 + 32'(4 * i), d[32*i +: 32], 1'b1}) begin
        n_fail++;
        $display("FAIL wb_beat%0d got adr=%h veri=%h yaz=%0b exp adr=%h veri=%h yaz=1",
                 i, obs_adr[i], obs_dat[i], obs_yaz[i], 32'h8000_0040 + 32'(4 * i), d[32*i +: 32]);
      end
    end
    n_tests++;
    if (obs_hz_cyc != 5 || obs_obek !== exp_obek) begin
      n_fail++; $display("FAIL wb_done got hazir=%0d obek=%h exp 5 %h", obs_hz_cyc, obs_obek, exp_obek);
    end
    step();
    n_tests++;
    if (bus.hazir_o !== 1'b0 || bus.musait_o !== 1'b1) begin
      n_fail++; $display("FAIL wb_pulse got hz=%0b musait=%0b exp 0 1", bus.hazir_o, bus.musait_o);
    end
  endtask

  task automatic test_chained();
    noise = 0; salt = $urandom;
    foreach (stall[i]) stall[i] = 0;
    do_burst(1'b1, 32'h0000_5A50, {$urandom, $urandom, $urandom, $urandom});
    n_tests++;
    if (obs_hz_cyc != 5 || bus.musait_o !== 1'b1) begin
      n_fail++; $display("FAIL chain_wb got hazir=%0d musait=%0b exp 5 1", obs_hz_cyc, bus.musait_o);
    end
    do_burst(1'b0, 32'h0000_0040, '0);
    exp_obek = model_read(32'h0000_0040);
    n_tests++;
    if (obs_first_cyc != 1 || obs_adr[0] !== 32'h40 || obs_yaz[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL chain_first got cyc=%0d adr=%h yaz=%0b exp 1 00000040 0", obs_first_cyc, obs_adr[0], obs_yaz[0]);
    end
    n_tests++;
    if (obs_hz_cyc != 5 || obs_obek !== exp_obek) begin
      n_fail++; $display("FAIL chain_rd got hazir=%0d obek=%h exp 5 %h", obs_hz_cyc, obs_obek, exp_obek);
    end
    step();
  endtask

  task automatic test_stall();
    noise = 0; salt = $urandom;
    foreach (stall[i]) stall[i] = 3;
    do_burst(1'b0, 32'hC0DE_F00C, '0);
    exp_obek = model_read(32'hC0DE_F00C);
    n_tests++;
    if (obs_hz_cyc != 17 || obs_unstable != 0) begin
      n_fail++; $display("FAIL stall_timing got hazir=%0d unstable=%0d exp 17 0", obs_hz_cyc, obs_unstable);
    end
    n_tests++;
    if (obs_obek !== exp_obek) begin
      n_fail++; $display("FAIL stall_obek got %h exp %h", obs_obek, exp_obek);
    end
    step();
  endtask

  task automatic test_invalid_busy();
    logic [127:0] d;
    idle_inputs();
    bus.istek_i = 1'b1; bus.yaz_i = 1'b1; bus.oku_i = 1'b1;
    step();
    idle_inputs();
    bus.istek_i = 1'b1;
    step();
    idle_inputs();
    n_tests++;
    if (bus.bellek_istek_o !== 1'b0 || bus.musait_o !== 1'b1) begin
      n_fail++; $display("FAIL invalid_req got ist=%0b musait=%0b exp 0 1", bus.bellek_istek_o, bus.musait_o);
    end
    step();
    n_tests++;
    if (bus.bellek_istek_o !== 1'b0) begin
      n_fail++; $display("FAIL invalid_req2 got ist=%0b exp 0", bus.bellek_istek_o);
    end
    noise = 1; salt = $urandom;
    foreach (stall[i]) stall[i] = $urandom_range(0, 2);
    d = {$urandom, $urandom, $urandom, $urandom};
    do_burst(1'b1, 32'h1111_2220, d);
    n_tests++;
    if (obs_beats != 4 || obs_adr[3] !== 32'h1111_222C || obs_dat[3] !== d[127:96] || obs_unstable != 0) begin
      n_fail++;
      $display("FAIL busy_burst got beats=%0d adr3=%h veri3=%h unstable=%0d exp 4 1111222c %h 0",
               obs_beats, obs_adr[3], obs_dat[3], obs_unstable, d[127:96]);
    end
    step();
    n_tests++;
    if (bus.bellek_istek_o !== 1'b0 || bus.hazir_o !== 1'b0) begin
      n_fail++; $display("FAIL busy_after got ist=%0b hz=%0b exp 0 0", bus.bellek_istek_o, bus.hazir_o);
    end
  endtask

  task automatic test_back_to_back();
    logic wr;
    logic [31:0] adr, base;
    logic [127:0] d;
    int exp_cyc;
    for (int n = 0; n < 20; n++) begin
      wr = $urandom_range(0, 1);
      adr = $urandom;
      base = {adr[31:4], 4'h0};
      d = {$urandom, $urandom, $urandom, $urandom};
      salt = $urandom;
      noise = $urandom_range(0, 1);
      exp_cyc = 1;
      foreach (stall[i]) begin
        stall[i] = $urandom_range(0, 2);
        exp_cyc += stall[i] + 1;
      end
      do_burst(wr, adr, d);
      if (!wr) exp_obek = model_read(adr);
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if ({obs_adr[i], obs_dat[i], obs_yaz[i]} !== {base + 32'(4 * i), wr ? d[32*i +: 32] : 32'h0, wr}) begin
          n_fail++;
          $display("FAIL b2b%0d_beat%0d got adr=%h veri=%h yaz=%0b exp adr=%h veri=%h yaz=%0b", n, i,
                   obs_adr[i], obs_dat[i], obs_yaz[i], base + 32'(4 * i), wr ? d[32*i +: 32] : 32'h0, wr);
        end
      end
      n_tests++;
      if (obs_hz_cyc != exp_cyc || obs_unstable != 0 || obs_obek !== exp_obek) begin
        n_fail++;
        $display("FAIL b2b%0d_done got hazir=%0d unstable=%0d obek=%h exp %0d 0 %h",
                 n, obs_hz_cyc, obs_unstable, obs_obek, exp_cyc, exp_obek);
      end
    end
    step();
  endtask

  task automatic test_reset_mid();
    int hz_seen;
    noise = 0; salt = $urandom;
    idle_inputs();
    bus.istek_i = 1'b1; bus.oku_i = 1'b1; bus.adres_i = 32'h0000_2000;
    step();
    idle_inputs();
    bus.bellek_kabul_i = 1'b1; bus.bellek_veri_i = mem_word(bus.bellek_adres_o);
    step();
    bus.bellek_veri_i = mem_word(bus.bellek_adres_o);
    step();
    bus.bellek_kabul_i = 1'b0;
    n_tests++;
    if (bus.bellek_istek_o !== 1'b1 || bus.bellek_adres_o !== 32'h0000_2008) begin
      n_fail++; $display("FAIL rst_beat2 got ist=%0b adr=%h exp 1 00002008", bus.bellek_istek_o, bus.bellek_adres_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.hazir_o, bus.bellek_istek_o, bus.bellek_yaz_o, bus.bellek_adres_o, bus.bellek_veri_o} !== '0 ||
        bus.obek_o !== 128'h0 || bus.musait_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_async got hz=%0b ist=%0b adr=%h obek=%h musait=%0b exp 0 0 0 0 1",
               bus.hazir_o, bus.bellek_istek_o, bus.bellek_adres_o, bus.obek_o, bus.musait_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_obek = '0;
    hz_seen = 0;
    bus.bellek_kabul_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.hazir_o || bus.bellek_istek_o) hz_seen++;
    end
    bus.bellek_kabul_i = 1'b0;
    n_tests++;
    if (hz_seen != 0 || bus.musait_o !== 1'b1 || bus.obek_o !== 128'h0) begin
      n_fail++;
      $display("FAIL rst_after got activity=%0d musait=%0b obek=%h exp 0 1 0", hz_seen, bus.musait_o, bus.obek_o);
    end
  endtask

  initial begin
    idle_inputs();
    exp_obek = '0;
    #1 rst_n = 1'b0;
    #2;
    test_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    test_read_basic();
    test_write_back();
    test_chained();
    test_stall();
    test_invalid_busy();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/anabellek_denetleyici.md
# anabellek_denetleyici

Main-memory controller sitting directly downstream of the data-cache wrapper. It accepts 128-bit block read (refill) and write-back requests from the cache and executes each as a 4-beat burst of 32-bit word transfers on the memory-side request/accept bus. Read data is assembled into a block; a one-cycle ready pulse then returns control to the cache.

## Interface
- OBEK_BIT, 128: block width; fixed.
- VERI_BIT, 32: memory word width; beat count = OBEK_BIT/VERI_BIT = 4.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- istek_i  in  1  cache request strobe.
- yaz_i  in  1  request is a write-back.
- oku_i  in  1  request is a refill read.
- adres_i  in  32  block address; bits [3:0] ignored.
- kirli_obek_i  in  128  write-back data; sampled at acceptance.
- musait_o  out  1  controller can accept a request this cycle.
- hazir_o  out  1  one-cycle completion pulse.
- obek_o  out  128  last assembled read block.
- bellek_istek_o  out  1  beat request valid.
- bellek_yaz_o  out  1  beat is a write.
- bellek_adres_o  out  32  beat word address.
- bellek_veri_o  out  32  beat write data.
- bellek_kabul_i  in  1  memory accepts current beat; read data valid same cycle.
- bellek_veri_i  in  32  read word, valid when bellek_kabul_i=1 on a read beat.

## Operation
- States: BOSTA, VURUS (beats in flight), TAMAM (completion).
- musait_o = (state==BOSTA) || (state==TAMAM).
- Acceptance: istek_i && musait_o && (yaz_i XOR oku_i). Latch base = {adres_i[31:4],4'b0}, direction, kirli_obek_i; clear beat counter; go to VURUS.
- istek_i with yaz_i==oku_i, or while musait_o=0: ignored, no state change.
- VURUS: bellek_istek_o=1, bellek_yaz_o=latched direction, bellek_adres_o=base+4k, bellek_veri_o=block[32k+:32] (write), 0 (read). k = beat counter 0..3.
- On bellek_kabul_i in VURUS: read beats store bellek_veri_i into obek_o[32k+:32]; k increments. On kabul of k=3 go to TAMAM.
- TAMAM: hazir_o=1 for exactly one cycle; bellek_istek_o=0. Next state BOSTA, or VURUS if a new request is accepted in this cycle (write-back followed by chained refill).
- obek_o updates only on read beats; unchanged by write bursts; holds value indefinitely.
- Beat address arithmetic is 32-bit; base is block-aligned so base+12 never carries past bit 3.

## Timing
- Reset (asynchronous assert, synchronous deassert effect): state BOSTA, k=0, musait_o=1, hazir_o=0, obek_o=0, bellek_istek_o=0, bellek_yaz_o=0, bellek_adres_o=0, bellek_veri_o=0.
- Reset mid-burst: burst aborted immediately, outputs to reset values, no hazir_o, obek_o cleared.
- All outputs registered except musait_o (decoded from state register, no combinational path from inputs).
- Request accepted at edge ending cycle T: beat 0 presented in T+1.
- Beat held stable (address, data, yaz) until the cycle bellek_kabul_i=1; next beat presented the following cycle; with kabul tied high, beats in T+1..T+4, hazir_o in T+5.
- Each cycle kabul_i=0 during VURUS adds one cycle of latency; no timeout.
- obek_o valid and complete in the hazir_o cycle of a read.
- bellek_kabul_i outside VURUS: ignored.

## Test plan
- Read, kabul tied high, adres_i=0x0000_1234, memory word at addr A = A: beats at 0x1230/34/38/3C in T+1..T+4; hazir_o in T+5; obek_o=0x0000123C_00001238_00001234_00001230.
- Write-back adres_i=0x8000_0040, kirli_obek_i=0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA: bellek_veri_o sequence AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD with yaz=1; obek_o unchanged; hazir_o single pulse.
- Chained: write-back, then istek_i+oku_i with adres 0x40 in the hazir_o cycle: accepted, read beat 0 at 0x40 next cycle, no BOSTA cycle between.
- Stalls: kabul low 3 cycles before each beat: each beat held stable, hazir_o at T+17.
- Invalid/busy: istek_i with yaz_i=oku_i=1 in BOSTA, and valid istek_i during VURUS: both ignored, current burst unaffected.
- Reset asserted during beat 2 of a read: all outputs at reset values asynchronously; after release musait_o=1, no hazir_o, obek_o=0.
